// File: rtl/oai222_arc_exerciser.sv
// Sweeps all 54 sensitized OAI222 timing arcs (INIT/RISE/FALL per arc) and checks ZN.
// Optional first-fail capture of arc index and phase: define FIRST_FAIL_CAPTURE_EN.
module oai222_arc_exerciser #(
  parameter int SETTLE_CYC = 2,
  parameter int FAIL_W     = 8
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              ZN,
  output logic              A1,
  output logic              A2,
  output logic              B1,
  output logic              B2,
  output logic              C1,
  output logic              C2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [5:0]        ff_arc,
  output logic [1:0]        ff_phase
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [1:0] PH_INIT     = 2'd0;
  localparam logic [1:0] PH_RISE     = 2'd1;
  localparam logic [1:0] PH_FALL     = 2'd2;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_pin;
  logic [3:0]          r_cond;
  logic [1:0]          r_phase;
  logic [3:0]          r_settle;
  logic [5:0]          r_drive;
  logic                r_done;
  logic [FAIL_W-1:0]   r_fail;
  logic                w_mismatch;
  logic                w_last;

  // Pair values 1..3 map to {X1,X2}; the toggled pin's own pair carries only that pin.
  function automatic logic [5:0] phase_vec(input logic [2:0] pin, input logic [3:0] cond,
                                           input logic [1:0] ph);
    logic [1:0] outer;
    logic [1:0] inner;
    logic [1:0] own;
    outer = 2'(cond / 4'd3) + 2'd1;
    inner = 2'(cond % 4'd3) + 2'd1;
    own   = 2'b00;
    if (ph == PH_RISE) own = pin[0] ? 2'b01 : 2'b10;
    case (pin[2:1])
      2'd0:    phase_vec = {own, outer, inner};
      2'd1:    phase_vec = {outer, own, inner};
      default: phase_vec = {outer, inner, own};
    endcase
  endfunction

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_mismatch = (ZN != (r_phase != PH_RISE));
  assign w_last     = (r_pin == 3'd5) && (r_cond == 4'd8) && (r_phase == PH_FALL);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_APPLY;
      S_APPLY:  w_next = S_SETTLE;
      S_SETTLE: if (r_settle == 4'd0) w_next = S_CHECK;
      S_CHECK:  w_next = w_last ? S_DONE : S_APPLY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_pin    <= '0;
      r_cond   <= '0;
      r_phase  <= PH_INIT;
      r_settle <= '0;
      r_drive  <= '0;
      r_done   <= 1'b0;
      r_fail   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_pin   <= '0;
          r_cond  <= '0;
          r_phase <= PH_INIT;
          r_done  <= 1'b0;
          r_fail  <= '0;
        end
        S_APPLY: begin
          r_drive  <= phase_vec(r_pin, r_cond, r_phase);
          r_settle <= SETTLE_LOAD;
        end
        S_SETTLE: if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        S_CHECK: begin
          if (w_mismatch) r_fail <= sat_inc(r_fail);
          // Phase is the fastest index, then side condition, then pin.
          if (r_phase == PH_FALL) begin
            r_phase <= PH_INIT;
            if (r_cond == 4'd8) begin
              r_cond <= '0;
              r_pin  <= r_pin + 3'd1;
            end else begin
              r_cond <= r_cond + 4'd1;
            end
          end else begin
            r_phase <= r_phase + 2'd1;
          end
        end
        S_DONE: begin
          r_drive <= '0;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [5:0] r_ff_arc;
  logic [1:0] r_ff_phase;
  logic [5:0] w_arc;

  assign w_arc = 6'(r_pin) * 6'd9 + 6'(r_cond);

  // fail_cnt is still zero on the first mismatch of a sweep.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_ff_arc   <= '0;
      r_ff_phase <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_ff_arc   <= '0;
      r_ff_phase <= '0;
    end else if (r_state == S_CHECK && w_mismatch && r_fail == '0) begin
      r_ff_arc   <= w_arc;
      r_ff_phase <= r_phase;
    end
  end

  assign ff_arc   = r_ff_arc;
  assign ff_phase = r_ff_phase;
`else
  assign ff_arc   = '0;
  assign ff_phase = '0;
`endif

  assign {A1, A2, B1, B2, C1, C2} = r_drive;
  assign busy     = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done     = r_done;
  assign pass     = r_done && (r_fail == '0);
  assign fail_cnt = r_fail;

endmodule

// File: tb/tb_oai222_arc_exerciser.sv
// Bench for oai222_arc_exerciser: behavioural OAI222 cell with injectable faults and a
// cycle-indexed model of the sweep (vector, busy, done, counts) checked every cycle.
module tb_oai222_arc_exerciser;

  localparam int SETTLE_CYC = 2;
  localparam int FAIL_W     = 8;
  localparam int P          = SETTLE_CYC + 2;
  localparam int NPH        = 162;
  localparam int LEN        = NPH * P;
  localparam int OW         = 17 + FAIL_W;

  logic              CK    = 1'b0;
  logic              RST   = 1'b1;
  logic              start = 1'b0;
  logic              ZN;
  logic              A1, A2, B1, B2, C1, C2;
  logic              busy, done, pass;
  logic [FAIL_W-1:0] fail_cnt;
  logic [5:0]        ff_arc;
  logic [1:0]        ff_phase;

  int             checks   = 0;
  int             failures = 0;
  int             fault    = 0;
  bit [NPH-1:0]   mm_next  = '0;
  bit [NPH-1:0]   mm_cur   = '0;
  int             k        = -1;

  oai222_arc_exerciser #(.SETTLE_CYC(SETTLE_CYC), .FAIL_W(FAIL_W)) dut (
    .CK(CK), .RST(RST), .start(start), .ZN(ZN),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .ff_arc(ff_arc), .ff_phase(ff_phase)
  );

  always #5 CK = ~CK;

  // Vector for global phase j = arc*3 + phase, returned as {A1,A2,B1,B2,C1,C2}.
  function automatic logic [5:0] spec_vec(input int j);
    int         arc, ph, pin, cond, grp, side;
    logic       b[6];
    logic [1:0] v;
    arc  = j / 3;
    ph   = j % 3;
    pin  = arc / 9;
    cond = arc % 9;
    grp  = pin / 2;
    side = 0;
    for (int i = 0; i < 6; i++) b[i] = 1'b0;
    for (int g = 0; g < 3; g++) begin
      if (g != grp) begin
        v = (side == 0) ? 2'(cond / 3 + 1) : 2'(cond % 3 + 1);
        b[2*g]   = v[1];
        b[2*g+1] = v[0];
        side++;
      end
    end
    b[pin] = (ph == 1);
    return {b[0], b[1], b[2], b[3], b[4], b[5]};
  endfunction

  // Fault 0 good, 1 ZN stuck-at-1, 2 ZN stuck-at-0, 3 C2 input tied low.
  function automatic logic cell_zn(input logic [5:0] v, input int f);
    logic [5:0] w;
    w = v;
    if (f == 1) return 1'b1;
    if (f == 2) return 1'b0;
    if (f == 3) w[0] = 1'b0;
    return !((w[5] | w[4]) & (w[3] | w[2]) & (w[1] | w[0]));
  endfunction

  assign ZN = cell_zn({A1, A2, B1, B2, C1, C2}, fault);

  task automatic set_fault(input int f);
    fault = f;
    for (int j = 0; j < NPH; j++)
      mm_next[j] = (cell_zn(spec_vec(j), f) != ((j % 3) != 1));
  endtask

  // k counts cycles since the accepted start; the sweep snapshot is taken on acceptance.
  always @(posedge CK or posedge RST) begin
    if (RST) begin
      k <= -1;
    end else if (start && (k < 0 || k > LEN)) begin
      k      <= 0;
      mm_cur <= mm_next;
    end else if (k >= 0 && k <= LEN + 1) begin
      k <= k + 1;
    end
  end

  function automatic logic [OW-1:0] exp_out(input int kk);
    logic [5:0]        drv;
    logic              bsy, dn;
    logic [FAIL_W-1:0] fc;
    logic [5:0]        fa;
    logic [1:0]        fp;
    int                nc;
    bit                seen;
    drv = '0; bsy = 1'b0; dn = 1'b0; fc = '0; fa = '0; fp = '0; seen = 1'b0;
    if (kk >= 0) begin
      bsy = (kk < LEN);
      dn  = (kk > LEN);
      if (kk <= LEN) begin
        if (kk % P == 0) drv = (kk == 0) ? 6'd0 : spec_vec(kk / P - 1);
        else             drv = spec_vec(kk / P);
      end
      nc = (kk / P > NPH) ? NPH : kk / P;
      for (int j = 0; j < nc; j++) begin
        if (mm_cur[j]) begin
          if (!seen) begin
            fa   = 6'(j / 3);
            fp   = 2'(j % 3);
            seen = 1'b1;
          end
          fc = fc + 1'b1;
        end
      end
    end
`ifndef FIRST_FAIL_CAPTURE_EN
    fa = '0;
    fp = '0;
`endif
    return {drv, bsy, dn, dn && (fc == '0), fc, fa, fp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin : compare
    logic [OW-1:0] act;
    logic [OW-1:0] expv;
    forever begin
      @(negedge CK);
      act  = {A1, A2, B1, B2, C1, C2, busy, done, pass, fail_cnt, ff_arc, ff_phase};
      expv = exp_out(k);
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL cycle_outputs k=%0d actual=%h required=%h", k, act, expv);
      end
    end
  end

  task automatic sweep(input string name, input int f, input bit poke,
                       input int exp_fail, input int exp_arc, input int exp_ph);
    int cnt;
    bit ended;
    set_fault(f);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    cnt   = 0;
    ended = 1'b0;
    for (int i = 0; i < LEN + 100; i++) begin
      if (busy) cnt++;
      else if (cnt > 0) begin
        ended = 1'b1;
        break;
      end
      start = poke && (cnt == 10);
      @(negedge CK);
    end
    chk({name, "_ended"}, 32'(ended), 32'd1);
    chk({name, "_busy_len"}, cnt, 648);
    start = poke;
    @(negedge CK);
    start = 1'b0;
    @(negedge CK);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_pass"}, 32'(pass), 32'(exp_fail == 0));
    chk({name, "_fail_cnt"}, 32'(fail_cnt), exp_fail);
    chk({name, "_drive_zero"}, 32'({A1, A2, B1, B2, C1, C2}), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({name, "_ff_arc"}, 32'(ff_arc), exp_arc);
    chk({name, "_ff_phase"}, 32'(ff_phase), exp_ph);
`else
    chk({name, "_ff_arc_tied"}, 32'(ff_arc), 32'd0);
    chk({name, "_ff_phase_tied"}, 32'(ff_phase), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge CK);
    chk("reset_outputs",
        32'({A1, A2, B1, B2, C1, C2, busy, done, pass, fail_cnt, ff_arc, ff_phase}), 32'd0);
    RST = 1'b0;
    @(negedge CK);

    chk("vec_arc0_init",  32'(spec_vec(0)),   32'b000101);
    chk("vec_arc0_rise",  32'(spec_vec(1)),   32'b100101);
    chk("vec_arc22_rise", 32'(spec_vec(67)),  32'b101010);
    chk("vec_arc53_rise", 32'(spec_vec(160)), 32'b111101);

    set_fault(1);
    chk("model_stuck1_count", $countones(mm_next), 54);
    set_fault(2);
    chk("model_stuck0_count", $countones(mm_next), 108);
    set_fault(3);
    chk("model_c2tied_count", $countones(mm_next), 21);
    n = 0;
    for (int j = 135; j < NPH; j++) if (mm_next[j] && (j % 3 == 1)) n++;
    chk("model_c2tied_c2_arcs_rise", n, 9);

    sweep("good",   0, 1'b0, 0,   0, 0);
    sweep("stuck1", 1, 1'b0, 54,  0, 1);
    sweep("stuck0", 2, 1'b0, 108, 0, 0);
    sweep("c2tied", 3, 1'b0, 21,  0, 1);

    set_fault(0);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    repeat (299) @(negedge CK);
    #1;
    RST = 1'b1;
    #1;
    chk("midsweep_reset_outputs",
        32'({A1, A2, B1, B2, C1, C2, busy, done, pass, fail_cnt, ff_arc, ff_phase}), 32'd0);
    repeat (2) @(negedge CK);
    RST = 1'b0;
    @(negedge CK);

    sweep("after_reset", 0, 1'b0, 0, 0, 0);
    sweep("ignored_starts", 0, 1'b1, 0, 0, 0);
    repeat (3) @(negedge CK);
    chk("done_held", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
